unit_test_sequencer: RTL and testbench

Synthesizable initiator for the per-unit start/finish test handshake used by the CPU self-test harness (ALU, register file, memory, and similar unit tests).
- Drives `start` to each attached unit test in index order and waits for its `finish`.
- Samples each test's pass flag and enforces a per-test timeout.
- Reports aggregate results to the top-level bench or board LEDs.
- Sits above the unit-test responders; one instance per harness.

---
 rtl/unit_test_sequencer_pkg.sv | 15 +
 rtl/unit_test_sequencer_watchdog_counter.sv | 35 +++
 rtl/unit_test_sequencer.sv | 135 +++++++++++++
 tb/tb_unit_test_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/unit_test_sequencer_pkg.sv
// Shared definitions for the unit-test sequencer.
// Holds the FSM state encoding and the width of the test index.
package unit_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  localparam int IDX_W = 4;

endpackage

// File: rtl/unit_test_sequencer_watchdog_counter.sv
// Per-test watchdog for the sequencer.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   clr       - return the count to zero (takes priority over en)
//   en        - advance the count by one
//   expired   - count has reached TIMEOUT-1
// The count stops at TIMEOUT-1, so it cannot wrap while a test hangs.
module watchdog_counter #(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/unit_test_sequencer.sv
// Start/finish handshake initiator for the CPU self-test harness.
// Runs each attached unit test in index order, records pass/fail and
// hung tests, and reports the aggregate result.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   go            - run request (honoured in IDLE and DONE)
//   test_start    - one-hot level start to unit test i
//   test_finish   - finish level from unit test i
//   test_pass     - pass flag from unit test i, valid with its finish
//   busy          - run in progress
//   cur_idx       - index of the test being run
//   done          - run complete, results held
//   all_pass      - while done: every test finished and passed
//   fail_mask     - bit i: test i finished with pass low
//   timeout_mask  - bit i: test i hit the watchdog
//
// state | meaning
// IDLE  | waiting for go after reset
// START | raise start for cur_idx, clear watchdog
// WAIT  | hold start, wait for finish or watchdog expiry
// GAP   | drop start for one cycle, then advance or finish
// DONE  | results held; go restarts the run
module unit_test_sequencer
  import unit_test_sequencer_pkg::*;
#(
  parameter int N_TESTS   = 4,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic [N_TESTS-1:0] test_start,
  input  logic [N_TESTS-1:0] test_finish,
  input  logic [N_TESTS-1:0] test_pass,
  output logic               busy,
  output logic [IDX_W-1:0]   cur_idx,
  output logic               done,
  output logic               all_pass,
  output logic [N_TESTS-1:0] fail_mask,
  output logic [N_TESTS-1:0] timeout_mask
);

  seq_state_t         state, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_TESTS-1:0] fail_q, fail_d;
  logic [N_TESTS-1:0] tmo_q, tmo_d;
  logic [N_TESTS-1:0] sel;
  logic               finish_cur, pass_cur, last_idx;
  logic               wd_clr, wd_en, wd_expired;

  // Select the current test by mask rather than bit index so the 4-bit
  // index can address any N_TESTS without a width mismatch.
  assign sel        = N_TESTS'(1) << idx_q;
  assign finish_cur = |(test_finish & sel);
  assign pass_cur   = |(test_pass & sel);
  assign last_idx   = (idx_q == IDX_W'(N_TESTS - 1));

  watchdog_counter #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx_q  <= '0;
      fail_q <= '0;
      tmo_q  <= '0;
    end else begin
      state  <= state_d;
      idx_q  <= idx_d;
      fail_q <= fail_d;
      tmo_q  <= tmo_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d = ST_START;
          idx_d   = '0;
          fail_d  = '0;
          tmo_d   = '0;
        end
      end
      ST_START: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // Finish is checked first so a finish on the expiry cycle wins.
        if (finish_cur) begin
          fail_d  = pass_cur ? (fail_q & ~sel) : (fail_q | sel);
          state_d = ST_GAP;
        end else if (wd_expired) begin
          tmo_d   = tmo_q | sel;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign test_start   = (state == ST_START || state == ST_WAIT) ? sel : '0;
  assign busy         = (state == ST_START || state == ST_WAIT || state == ST_GAP);
  assign done         = (state == ST_DONE);
  assign all_pass     = done & ~|fail_q & ~|tmo_q;
  assign cur_idx      = idx_q;
  assign fail_mask    = fail_q;
  assign timeout_mask = tmo_q;

endmodule

// File: tb/tb_unit_test_sequencer.sv
module tb_unit_test_sequencer;
  localparam int N  = 4;
  localparam int TW = 16;
  localparam int TO = 16;
  localparam int HANG = 255;

  logic         clk = 1'b0;
  logic         rst, go;
  logic [N-1:0] test_start, test_finish, test_pass;
  logic         busy, done, all_pass;
  logic [3:0]   cur_idx;
  logic [N-1:0] fail_mask, timeout_mask;

  unit_test_sequencer #(.N_TESTS(N), .TIMEOUT_W(TW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .test_start   (test_start),
    .test_finish  (test_finish),
    .test_pass    (test_pass),
    .busy         (busy),
    .cur_idx      (cur_idx),
    .done         (done),
    .all_pass     (all_pass),
    .fail_mask    (fail_mask),
    .timeout_mask (timeout_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] fmask;
    logic [N-1:0] tmask;
    logic         ap;
    int           cycles;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           lat[N];
  logic [N-1:0] cfg_pass;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: test i finishes on WAIT cycle max(lat,1) unless that is past
  // TIMEOUT; each test costs START + its WAIT cycles + GAP.
  function automatic exp_t model(input int lt[N], input logic [N-1:0] ps);
    exp_t e;
    int   fin_at;
    e.fmask = '0;
    e.tmask = '0;
    e.cycles = 0;
    for (int i = 0; i < N; i++) begin
      fin_at = (lt[i] < 1) ? 1 : lt[i];
      if (fin_at <= TO) begin
        if (!ps[i]) e.fmask[i] = 1'b1;
        e.cycles += 2 + fin_at;
      end else begin
        e.tmask[i] = 1'b1;
        e.cycles += 2 + TO;
      end
    end
    e.ap = (e.fmask == '0) && (e.tmask == '0);
    return e;
  endfunction

  // Responders: finish rises lat cycles after start was first seen high;
  // inactive tests present random finish/pass noise.
  initial begin
    int age[N];
    test_finish = '0;
    test_pass   = '0;
    for (int i = 0; i < N; i++) age[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (test_start[i]) begin
          age[i]++;
          test_finish[i] = (age[i] > lat[i]);
          test_pass[i]   = cfg_pass[i];
        end else begin
          age[i] = 0;
          test_finish[i] = 1'($urandom);
          test_pass[i]   = 1'($urandom);
        end
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard compare when done rises.
  initial begin
    logic         done_p, busy_p;
    logic [N-1:0] ts_p;
    int           cyc, nxt;
    exp_t         e;
    done_p = 1'b0; busy_p = 1'b0; ts_p = '0; cyc = 0; nxt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy && !busy_p) begin
          cyc = 0;
          nxt = 0;
        end
        if (busy) cyc++;
        chk("start_onehot", $countones(test_start) <= 1, 1);
        if (test_start != '0) begin
          chk("start_matches_idx", test_start, N'(1) << cur_idx);
          if (test_start != ts_p) begin
            chk("start_order", test_start, N'(1) << nxt);
            nxt++;
          end
        end
        if (!busy) chk("start_zero_not_busy", test_start, 0);
        if (!done) chk("all_pass_not_done", all_pass, 0);
        if (done && !done_p) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("fail_mask", fail_mask, e.fmask);
            chk("timeout_mask", timeout_mask, e.tmask);
            chk("all_pass", all_pass, e.ap);
            chk("run_cycles", cyc, e.cycles);
            chk("tests_started", nxt, N);
          end
        end
      end
      done_p = done;
      busy_p = busy;
      ts_p   = test_start;
    end
  end

  task automatic run(input int lt[N], input logic [N-1:0] ps);
    int n;
    lat = lt;
    cfg_pass = ps;
    sb.push_back(model(lt, ps));
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_done", done, 0);
    chk("go_cur_idx", cur_idx, 0);
    chk("go_fail_clear", fail_mask, 0);
    chk("go_tmo_clear", timeout_mask, 0);
    chk("go_start0", test_start, 1);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (!done) go = 1'($urandom);
    end
    go = 1'b0;
    chk("run_completes", done, 1);
    repeat (2) @(negedge clk);
    chk("done_hold", done, 1);
  endtask

  initial begin
    int           tl[N];
    logic [N-1:0] tp;
    int           r, n;
    rst = 1'b1;
    go  = 1'b0;
    for (int i = 0; i < N; i++) lat[i] = 1;
    cfg_pass = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", test_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_all_pass", all_pass, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_fail_mask", fail_mask, 0);
    chk("rst_tmo_mask", timeout_mask, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_go", busy, 0);

    tl = '{3, 3, 3, 3};        run(tl, 4'b1111);
    tl = '{3, 3, 3, 3};        run(tl, 4'b1011);
    tl = '{2, HANG, 4, 1};     run(tl, 4'b1111);
    tl = '{TO, 3, TO + 1, 1};  run(tl, 4'b1111);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        tl[i] = (r == 0) ? HANG : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(1, 20);
      end
      tp = N'($urandom);
      run(tl, tp);
    end

    // Reset in the middle of test 1's WAIT.
    tl = '{3, HANG, 3, 3};
    lat = tl;
    cfg_pass = '1;
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    n = 0;
    while (!(test_start[1] && cur_idx == 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_test1", test_start[1], 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_start", test_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_fail", fail_mask, 0);
    chk("midrst_tmo", timeout_mask, 0);
    chk("midrst_idx", cur_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    tl = '{1, 5, 2, 7};        run(tl, 4'b0110);
    tl = '{3, 3, 3, 3};        run(tl, 4'b1111);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "simulation time limit");
  end
endmodule
